// File: rtl/imem_loader_pkg.sv
// Shared types and framing constants for the boot-time instruction memory loader.
// Stream framing: 4-byte word count, N little-endian words, then one XOR checksum byte.
package imem_loader_pkg;

    typedef enum logic [2:0] {
        HDR,
        LOAD,
        CHECK,
        DONE,
        ERROR
    } state_e;

    localparam int HDR_BYTES      = 4;
    localparam int BYTES_PER_WORD = 4;

endpackage

// File: rtl/imem_loader_if.sv
// Byte-stream input and instruction-memory write port of the loader.
// The master drives the stream and observes writes; the slave is the loader itself.
interface imem_loader_if #(
    parameter int BITNESS     = 32,
    parameter int INSTR_WIDTH = 32
);
    logic                   byteValid_i;
    logic [7:0]             byteData_i;
    logic                   byteReady_o;
    logic                   wrEn_o;
    logic [BITNESS-1:0]     wrAddr_o;
    logic [INSTR_WIDTH-1:0] wrData_o;

    modport master (
        output byteValid_i,
        output byteData_i,
        input  byteReady_o,
        input  wrEn_o,
        input  wrAddr_o,
        input  wrData_o
    );

    modport slave (
        input  byteValid_i,
        input  byteData_i,
        output byteReady_o,
        output wrEn_o,
        output wrAddr_o,
        output wrData_o
    );
endinterface

// File: rtl/imem_loader_byte_assembler.sv
// Little-endian shift-in word builder; word_o/word_full_o are combinational on the 4th shifted byte.
// No backpressure of its own: it shifts whenever shift_i is high and holds otherwise.
module byte_assembler
    import imem_loader_pkg::*;
(
    input  logic                        clk_i,
    input  logic                        rst_i,
    input  logic                        shift_i,
    input  logic [7:0]                  byte_i,
    output logic [8*BYTES_PER_WORD-1:0] word_o,
    output logic                        word_full_o
);
    localparam int W  = 8 * BYTES_PER_WORD;
    localparam int CW = $clog2(BYTES_PER_WORD);

    logic [W-1:0]  buf_q, buf_d;
    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        buf_d       = buf_q;
        cnt_d       = cnt_q;
        word_full_o = 1'b0;
        if (shift_i) begin
            // First byte ends up in the low lane once the word is complete.
            buf_d = {byte_i, buf_q[W-1:8]};
            if (cnt_q == CW'(BYTES_PER_WORD - 1)) begin
                word_full_o = 1'b1;
                cnt_d       = '0;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
        word_o = buf_d;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            buf_q <= '0;
            cnt_q <= '0;
        end else begin
            buf_q <= buf_d;
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/imem_loader.sv
// Boot loader: parses header/payload/checksum, writes imem one cycle after each word's 4th byte.
// Ready is a pure state decode (1 byte/cycle in HDR/LOAD/CHECK, stalls indefinitely on !valid).
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int          BITNESS     = 32,
    parameter int          INSTR_WIDTH = 32,
    parameter int          DEPTH_WORDS = 1024,
    parameter int unsigned BASE_ADDR   = 0
) (
    input  logic             clk_i,
    input  logic             rst_i,
    imem_loader_if.slave     bus,
    output logic             cpuRst_o,
    output logic             done_o,
    output logic             error_o
);
    localparam int WW = 8 * BYTES_PER_WORD;
    localparam int NW = 8 * HDR_BYTES;

    state_e                 state_q, state_d;
    logic [NW-1:0]          n_q, n_d;
    logic [NW-1:0]          idx_q, idx_d;
    logic [7:0]             csum_q, csum_d;
    logic                   wr_en_q, wr_en_d;
    logic [BITNESS-1:0]     wr_addr_q, wr_addr_d;
    logic [INSTR_WIDTH-1:0] wr_data_q, wr_data_d;

    logic          rdy;
    logic          accept;
    logic          asm_shift;
    logic          asm_full;
    logic [WW-1:0] asm_word;

    assign rdy       = (state_q == HDR) || (state_q == LOAD) || (state_q == CHECK);
    assign accept    = bus.byteValid_i && rdy;
    assign asm_shift = accept && ((state_q == HDR) || (state_q == LOAD));

    byte_assembler u_asm (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .shift_i     (asm_shift),
        .byte_i      (bus.byteData_i),
        .word_o      (asm_word),
        .word_full_o (asm_full)
    );

    always_comb begin
        state_d   = state_q;
        n_d       = n_q;
        idx_d     = idx_q;
        csum_d    = csum_q;
        wr_en_d   = 1'b0;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;

        // The checksum covers header and payload only, never the checksum byte itself.
        if (asm_shift) begin
            csum_d = csum_q ^ bus.byteData_i;
        end

        unique case (state_q)
            HDR: begin
                if (asm_full) begin
                    n_d = NW'(asm_word);
                    if (n_d > NW'(DEPTH_WORDS)) begin
                        state_d = ERROR;
                    end else if (n_d == '0) begin
                        state_d = CHECK;
                    end else begin
                        state_d = LOAD;
                    end
                end
            end
            LOAD: begin
                if (asm_full) begin
                    wr_en_d   = 1'b1;
                    wr_data_d = INSTR_WIDTH'(asm_word);
                    wr_addr_d = BITNESS'(BASE_ADDR) + BITNESS'({idx_q, 2'b00});
                    idx_d     = idx_q + 1'b1;
                    if (idx_d == n_q) begin
                        state_d = CHECK;
                    end
                end
            end
            CHECK: begin
                if (accept) begin
                    state_d = (bus.byteData_i == csum_q) ? DONE : ERROR;
                end
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= HDR;
            n_q       <= '0;
            idx_q     <= '0;
            csum_q    <= '0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= BITNESS'(BASE_ADDR);
            wr_data_q <= '0;
        end else begin
            state_q   <= state_d;
            n_q       <= n_d;
            idx_q     <= idx_d;
            csum_q    <= csum_d;
            wr_en_q   <= wr_en_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
        end
    end

    assign bus.byteReady_o = rdy;
    assign bus.wrEn_o      = wr_en_q;
    assign bus.wrAddr_o    = wr_addr_q;
    assign bus.wrData_o    = wr_data_q;
    assign cpuRst_o        = (state_q != DONE);
    assign done_o          = (state_q == DONE);
    assign error_o         = (state_q == ERROR);

endmodule

// File: tb/tb_imem_loader.sv
// Scenario bench for imem_loader: expected writes are queued as stimulus is driven and
// matched by a write monitor; each scenario task checks status outputs inline.
module tb_imem_loader;

    localparam int DEPTH = 1024;

    logic clk_i = 1'b0;
    logic rst_i;
    logic cpuRst_o, done_o, error_o;

    imem_loader_if #(.BITNESS(32), .INSTR_WIDTH(32)) bus ();

    imem_loader #(
        .BITNESS     (32),
        .INSTR_WIDTH (32),
        .DEPTH_WORDS (DEPTH),
        .BASE_ADDR   (0)
    ) dut (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .bus      (bus),
        .cpuRst_o (cpuRst_o),
        .done_o   (done_o),
        .error_o  (error_o)
    );

    always #5 clk_i = ~clk_i;

    int errors = 0;
    int checks = 0;
    int cycle  = 0;
    int wr_count = 0;
    logic [31:0] exp_addr_q[$];
    logic [31:0] exp_data_q[$];
    int          wr_cycles[$];
    logic [31:0] img_q[$];
    logic [31:0] mon_a, mon_d;

    always @(posedge clk_i) cycle++;

    // Write monitor: every strobe must match the oldest queued expectation.
    always @(negedge clk_i) begin
        if (bus.wrEn_o === 1'b1) begin
            wr_count++;
            wr_cycles.push_back(cycle);
            checks++;
            if (exp_addr_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_write: addr=%h data=%h, no write expected", bus.wrAddr_o, bus.wrData_o);
            end else begin
                mon_a = exp_addr_q.pop_front();
                mon_d = exp_data_q.pop_front();
                if (bus.wrAddr_o !== mon_a || bus.wrData_o !== mon_d) begin
                    errors++;
                    $display("FAIL write: got addr=%h data=%h, want addr=%h data=%h",
                             bus.wrAddr_o, bus.wrData_o, mon_a, mon_d);
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic idle();
        bus.byteValid_i = 1'b0;
        bus.byteData_i  = 8'h00;
    endtask

    // Offers one byte starting at a negedge; returns at the negedge after it was accepted.
    task automatic send_byte(input logic [7:0] b, input bit gaps);
        int budget;
        if (gaps) begin
            repeat ($urandom_range(0, 2)) begin
                bus.byteValid_i = 1'b0;
                @(negedge clk_i);
            end
        end
        bus.byteValid_i = 1'b1;
        bus.byteData_i  = b;
        budget = 0;
        while (bus.byteReady_o !== 1'b1 && budget < 20) begin
            @(negedge clk_i);
            budget++;
        end
        if (budget >= 20) begin
            checks++;
            errors++;
            $display("FAIL ready_timeout: byteReady_o=%b for 20 cycles, want 1", bus.byteReady_o);
        end
        @(negedge clk_i);
    endtask

    // Header with count n, then every word of img_q; returns the XOR checksum of all bytes sent.
    task automatic send_image(input logic [31:0] n, input bit gaps, output logic [7:0] cs);
        logic [31:0] w;
        cs = 8'h00;
        for (int k = 0; k < 4; k++) begin
            cs = cs ^ n[8*k +: 8];
            send_byte(n[8*k +: 8], gaps);
        end
        for (int i = 0; i < img_q.size(); i++) begin
            w = img_q[i];
            exp_addr_q.push_back(32'(4 * i));
            exp_data_q.push_back(w);
            for (int k = 0; k < 4; k++) begin
                cs = cs ^ w[8*k +: 8];
                send_byte(w[8*k +: 8], gaps);
            end
        end
    endtask

    task automatic do_reset();
        rst_i = 1'b1;
        idle();
        @(negedge clk_i);
        @(negedge clk_i);
        rst_i = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        checks += 7;
        if (bus.byteReady_o !== 1'b1) begin errors++; $display("FAIL rst_ready: got %b want 1", bus.byteReady_o); end
        if (bus.wrEn_o !== 1'b0) begin errors++; $display("FAIL rst_wren: got %b want 0", bus.wrEn_o); end
        if (bus.wrAddr_o !== 32'h0) begin errors++; $display("FAIL rst_addr: got %h want 0", bus.wrAddr_o); end
        if (bus.wrData_o !== 32'h0) begin errors++; $display("FAIL rst_data: got %h want 0", bus.wrData_o); end
        if (cpuRst_o !== 1'b1) begin errors++; $display("FAIL rst_cpurst: got %b want 1", cpuRst_o); end
        if (done_o !== 1'b0) begin errors++; $display("FAIL rst_done: got %b want 0", done_o); end
        if (error_o !== 1'b0) begin errors++; $display("FAIL rst_error: got %b want 0", error_o); end
    endtask

    task automatic test_single_word();
        logic [7:0] stream [8];
        int w0;
        stream = '{8'h01, 8'h00, 8'h00, 8'h00, 8'h13, 8'h05, 8'hA0, 8'h00};
        do_reset();
        w0 = wr_count;
        exp_addr_q.push_back(32'h0);
        exp_data_q.push_back(32'h00A00513);
        for (int i = 0; i < 8; i++) send_byte(stream[i], 1'b0);
        send_byte(8'hB7, 1'b0);
        idle();
        checks += 5;
        if (done_o !== 1'b1) begin errors++; $display("FAIL single_done: got %b want 1", done_o); end
        if (cpuRst_o !== 1'b0) begin errors++; $display("FAIL single_cpurst: got %b want 0", cpuRst_o); end
        if (error_o !== 1'b0) begin errors++; $display("FAIL single_error: got %b want 0", error_o); end
        if (wr_count - w0 != 1) begin errors++; $display("FAIL single_writes: got %0d want 1", wr_count - w0); end
        if (exp_addr_q.size() != 0) begin errors++; $display("FAIL single_pending: %0d writes missing", exp_addr_q.size()); end
    endtask

    task automatic test_back_to_back();
        logic [7:0] cs;
        do_reset();
        img_q.delete();
        for (int i = 0; i < 3; i++) img_q.push_back($urandom);
        wr_cycles.delete();
        send_image(32'd3, 1'b0, cs);
        checks += 2;
        if (bus.wrEn_o !== 1'b1) begin errors++; $display("FAIL b2b_last_pulse_with_csum: wrEn_o=%b want 1", bus.wrEn_o); end
        if (bus.byteReady_o !== 1'b1) begin errors++; $display("FAIL b2b_csum_ready: got %b want 1", bus.byteReady_o); end
        send_byte(cs, 1'b0);
        idle();
        checks += 4;
        if (wr_cycles.size() != 3) begin
            errors++;
            $display("FAIL b2b_count: got %0d writes want 3", wr_cycles.size());
        end else begin
            if (wr_cycles[1] - wr_cycles[0] != 4) begin errors++; $display("FAIL b2b_gap01: got %0d want 4", wr_cycles[1] - wr_cycles[0]); end
            if (wr_cycles[2] - wr_cycles[1] != 4) begin errors++; $display("FAIL b2b_gap12: got %0d want 4", wr_cycles[2] - wr_cycles[1]); end
        end
        if (done_o !== 1'b1) begin errors++; $display("FAIL b2b_done: got %b want 1", done_o); end
    endtask

    task automatic test_zero_words();
        logic [7:0] cs;
        int w0;
        do_reset();
        img_q.delete();
        w0 = wr_count;
        send_image(32'd0, 1'b0, cs);
        send_byte(8'h00, 1'b0);
        idle();
        checks += 3;
        if (done_o !== 1'b1) begin errors++; $display("FAIL zero_done: got %b want 1", done_o); end
        if (cpuRst_o !== 1'b0) begin errors++; $display("FAIL zero_cpurst: got %b want 0", cpuRst_o); end
        if (wr_count != w0) begin errors++; $display("FAIL zero_writes: got %0d want 0", wr_count - w0); end
    endtask

    task automatic test_bad_checksum();
        logic [7:0] cs;
        do_reset();
        img_q.delete();
        img_q.push_back(32'hDEADBEEF);
        send_image(32'd1, 1'b0, cs);
        send_byte(cs ^ 8'h5A, 1'b0);
        idle();
        @(negedge clk_i);
        checks += 5;
        if (error_o !== 1'b1) begin errors++; $display("FAIL badcs_error: got %b want 1", error_o); end
        if (cpuRst_o !== 1'b1) begin errors++; $display("FAIL badcs_cpurst: got %b want 1", cpuRst_o); end
        if (bus.byteReady_o !== 1'b0) begin errors++; $display("FAIL badcs_ready: got %b want 0", bus.byteReady_o); end
        if (done_o !== 1'b0) begin errors++; $display("FAIL badcs_done: got %b want 0", done_o); end
        if (exp_addr_q.size() != 0) begin errors++; $display("FAIL badcs_pending: %0d writes missing", exp_addr_q.size()); end
    endtask

    task automatic test_oversize();
        logic [7:0] cs;
        int w0;
        do_reset();
        img_q.delete();
        w0 = wr_count;
        send_image(32'(DEPTH + 1), 1'b0, cs);
        checks += 3;
        if (error_o !== 1'b1) begin errors++; $display("FAIL over_error: got %b want 1", error_o); end
        if (bus.byteReady_o !== 1'b0) begin errors++; $display("FAIL over_ready: got %b want 0", bus.byteReady_o); end
        if (cpuRst_o !== 1'b1) begin errors++; $display("FAIL over_cpurst: got %b want 1", cpuRst_o); end
        bus.byteData_i = 8'hAA;
        repeat (6) @(negedge clk_i);
        idle();
        checks += 2;
        if (error_o !== 1'b1) begin errors++; $display("FAIL over_sticky: got %b want 1", error_o); end
        if (wr_count != w0) begin errors++; $display("FAIL over_writes: got %0d want 0", wr_count - w0); end
    endtask

    task automatic test_abort_reload();
        logic [7:0] cs;
        logic [31:0] n;
        int w0;
        do_reset();
        w0 = wr_count;
        n = 32'd2;
        for (int k = 0; k < 4; k++) send_byte(n[8*k +: 8], 1'b1);
        send_byte(8'h11, 1'b1);
        send_byte(8'h22, 1'b1);
        // Reset lands on an edge with a byte on offer: that byte must be dropped.
        bus.byteValid_i = 1'b1;
        bus.byteData_i  = 8'h33;
        rst_i = 1'b1;
        @(negedge clk_i);
        rst_i = 1'b0;
        idle();
        checks += 4;
        if (bus.wrEn_o !== 1'b0) begin errors++; $display("FAIL abort_wren: got %b want 0", bus.wrEn_o); end
        if (bus.byteReady_o !== 1'b1) begin errors++; $display("FAIL abort_ready: got %b want 1", bus.byteReady_o); end
        if (cpuRst_o !== 1'b1) begin errors++; $display("FAIL abort_cpurst: got %b want 1", cpuRst_o); end
        if (wr_count != w0) begin errors++; $display("FAIL abort_writes: got %0d want 0", wr_count - w0); end
        img_q.delete();
        img_q.push_back($urandom);
        img_q.push_back($urandom);
        send_image(32'd2, 1'b1, cs);
        send_byte(cs, 1'b1);
        idle();
        checks += 3;
        if (done_o !== 1'b1) begin errors++; $display("FAIL reload_done: got %b want 1", done_o); end
        if (wr_count - w0 != 2) begin errors++; $display("FAIL reload_writes: got %0d want 2", wr_count - w0); end
        if (exp_addr_q.size() != 0) begin errors++; $display("FAIL reload_pending: %0d writes missing", exp_addr_q.size()); end
    endtask

    initial begin
        rst_i = 1'b1;
        idle();
        @(negedge clk_i);
        test_reset();
        test_single_word();
        test_back_to_back();
        test_zero_words();
        test_bad_checksum();
        test_oversize();
        test_abort_reload();
        repeat (2) @(negedge clk_i);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
